// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - up/down modulo-M counter with deferred modulus update and clamped load
module prog_mod_counter #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] mod_active,
  output logic             mod_pending,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_MOD = WIDTH'(DEFAULT_MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q, pend_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;

  logic [WIDTH-1:0] mod_new;
  logic             at_top, at_zero;
  logic             apply;

  // Modulus that takes effect on an applying edge (wrap, clr or load).
  assign mod_new = pend_q ? pend_val_q : mod_q;
  assign at_top  = (count_q == (mod_q - ONE));
  assign at_zero = (count_q == '0);

  assign tc          = en & ((dir & at_top) | (~dir & at_zero));
  assign count       = count_q;
  assign wrap        = wrap_q;
  assign mod_active  = mod_q;
  assign mod_pending = pend_q;
  assign load_err    = load_err_q;

  always_comb begin
    count_d    = count_q;
    mod_d      = mod_q;
    pend_val_d = pend_val_q;
    pend_d     = pend_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    apply      = 1'b0;

    if (clr) begin
      count_d = '0;
      apply   = 1'b1;
    end else if (load) begin
      apply = 1'b1;
      if (load_val < mod_new) begin
        count_d = load_val;
      end else begin
        count_d    = mod_new - ONE;
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (dir) begin
        if (at_top) begin
          count_d = '0;
          wrap_d  = 1'b1;
          apply   = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (at_zero) begin
          // A down-wrap lands on the top of the modulus being applied.
          count_d = mod_new - ONE;
          wrap_d  = 1'b1;
          apply   = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end

    if (apply) begin
      mod_d  = mod_new;
      pend_d = 1'b0;
    end

    // A write on the applying edge becomes the next pending value.
    if (mod_wr && (mod_val != '0)) begin
      pend_val_d = mod_val;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      mod_q      <= RESET_MOD;
      pend_val_q <= '0;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      mod_q      <= mod_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

endmodule

// File: tb/tb_prog_mod_counter.sv
// tb/tb_prog_mod_counter.sv - vector table, corner sequences and random run against a reference model
module tb_prog_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, dir, clr, load, mod_wr;
  logic [7:0] load_val, mod_val;
  logic [7:0] count, mod_active;
  logic       tc, wrap, mod_pending, load_err;

  prog_mod_counter #(.WIDTH(8), .DEFAULT_MOD(10)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .clr(clr), .load(load),
    .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val), .count(count),
    .tc(tc), .wrap(wrap), .mod_active(mod_active), .mod_pending(mod_pending),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: state described as plain integers
  int m_cnt, m_mod, m_pval, m_wrap, m_err;
  bit m_pend;
  bit tc_seen, tc_model;

  typedef struct {
    bit e, d, c, l, mw;
    int lv, mv;
    bit x_tc;
    int x_cnt, x_wrap, x_mod, x_pend, x_err;
  } vec_t;
  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mod = 10; m_pend = 0; m_pval = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, d, c, l, input int lv, input bit mw, input int mv);
    int  mnew;
    bit  applied;
    mnew    = m_pend ? m_pval : m_mod;
    applied = 0;
    m_wrap  = 0;
    m_err   = 0;
    if (c) begin
      m_cnt = 0; applied = 1;
    end else if (l) begin
      applied = 1;
      m_err   = (lv >= mnew);
      m_cnt   = (lv < mnew) ? lv : mnew - 1;
    end else if (e) begin
      if (d) begin
        m_wrap = ((m_cnt + 1) == m_mod);
        m_cnt  = (m_cnt + 1) % m_mod;
      end else begin
        m_wrap = (m_cnt == 0);
        m_cnt  = m_wrap ? mnew - 1 : m_cnt - 1;
      end
      applied = m_wrap;
    end
    if (applied) begin
      m_mod = mnew; m_pend = 0;
    end
    if (mw && mv != 0) begin
      m_pend = 1; m_pval = mv;
    end
  endtask

  // Drive one cycle: sample tc before the edge, advance model, settle after the edge
  task automatic step(input bit e, d, c, l, input int lv, input bit mw, input int mv);
    en = e; dir = d; clr = c; load = l; load_val = 8'(lv); mod_wr = mw; mod_val = 8'(mv);
    #1;
    tc_seen  = tc;
    tc_model = e && ((d && m_cnt == m_mod - 1) || (!d && m_cnt == 0));
    @(posedge clk);
    model_edge(e, d, c, l, lv, mw, mv);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_tc"}, tc_seen, tc_model);
    chk({tag, "_count"}, count, m_cnt);
    chk({tag, "_wrap"}, wrap, m_wrap);
    chk({tag, "_mod_active"}, mod_active, m_mod);
    chk({tag, "_mod_pending"}, mod_pending, m_pend);
    chk({tag, "_load_err"}, load_err, m_err);
  endtask

  task automatic do_reset();
    rst_n = 0; en = 0; dir = 0; clr = 0; load = 0; mod_wr = 0; load_val = 0; mod_val = 0;
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  function automatic vec_t mk(bit e, d, c, l, int lv, bit mw, int mv,
                              bit xt, int xc, xw, xm, xp, xe);
    vec_t v;
    v.e = e; v.d = d; v.c = c; v.l = l; v.lv = lv; v.mw = mw; v.mv = mv;
    v.x_tc = xt; v.x_cnt = xc; v.x_wrap = xw; v.x_mod = xm; v.x_pend = xp; v.x_err = xe;
    return v;
  endfunction

  initial begin
    //          e d c l lv  mw mv  tc cnt wr mod pd er
    tbl[0]  = mk(0,0,0,1,15, 0,0,  0, 9, 0,10, 0, 1);
    tbl[1]  = mk(1,1,0,0, 0, 0,0,  1, 0, 1,10, 0, 0);
    tbl[2]  = mk(1,0,0,0, 0, 0,0,  1, 9, 1,10, 0, 0);
    tbl[3]  = mk(1,0,0,0, 0, 0,0,  0, 8, 0,10, 0, 0);
    tbl[4]  = mk(0,0,1,1, 3, 0,0,  0, 0, 0,10, 0, 0);
    tbl[5]  = mk(0,0,0,0, 0, 1,0,  0, 0, 0,10, 0, 0);
    tbl[6]  = mk(0,0,0,0, 0, 1,6,  0, 0, 0,10, 1, 0);
    tbl[7]  = mk(0,0,0,1, 7, 0,0,  0, 5, 0, 6, 0, 1);
    tbl[8]  = mk(1,1,0,0, 0, 0,0,  1, 0, 1, 6, 0, 0);
    tbl[9]  = mk(1,1,0,0, 0, 1,1,  0, 1, 0, 6, 1, 0);
    tbl[10] = mk(1,1,1,0, 0, 0,0,  0, 0, 0, 1, 0, 0);
    tbl[11] = mk(1,1,0,0, 0, 0,0,  1, 0, 1, 1, 0, 0);
    tbl[12] = mk(1,0,0,0, 0, 0,0,  1, 0, 1, 1, 0, 0);
    tbl[13] = mk(0,0,0,0, 0, 0,0,  0, 0, 0, 1, 0, 0);
    tbl[14] = mk(0,0,1,0, 0, 1,4,  0, 0, 0, 1, 1, 0);
    tbl[15] = mk(1,0,0,0, 0, 0,0,  1, 3, 1, 4, 0, 0);
    tbl[16] = mk(1,1,0,0, 0, 0,0,  1, 0, 1, 4, 0, 0);
    tbl[17] = mk(1,1,0,1, 2, 0,0,  0, 2, 0, 4, 0, 0);

    // Reset state
    do_reset();
    chk("reset_count", count, 0);
    chk("reset_mod", mod_active, 10);
    chk("reset_pending", mod_pending, 0);
    chk("reset_wrap", wrap, 0);
    chk("reset_load_err", load_err, 0);

    // Vector table
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].e, tbl[i].d, tbl[i].c, tbl[i].l, tbl[i].lv, tbl[i].mw, tbl[i].mv);
      chk($sformatf("vec%0d_tc", i), tc_seen, tbl[i].x_tc);
      chk($sformatf("vec%0d_count", i), count, tbl[i].x_cnt);
      chk($sformatf("vec%0d_wrap", i), wrap, tbl[i].x_wrap);
      chk($sformatf("vec%0d_mod", i), mod_active, tbl[i].x_mod);
      chk($sformatf("vec%0d_pend", i), mod_pending, tbl[i].x_pend);
      chk($sformatf("vec%0d_lerr", i), load_err, tbl[i].x_err);
    end

    // Up count through a wrap
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      chk($sformatf("up%0d_tc", i), tc_seen, (i % 10) == 9);
      chk($sformatf("up%0d_count", i), count, (i + 1) % 10);
      chk($sformatf("up%0d_wrap", i), wrap, (i % 10) == 9);
    end

    // Down count, then reverse direction at 5
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("down_first_count", count, 9);
    chk("down_first_wrap", wrap, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("down_at5", count, 5);
    chk("down_at5_wrap", wrap, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("dir_toggle_count", count, 6);

    // Deferred modulus applied at the next up-wrap
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 6);
    chk("defer_count", count, 5);
    chk("defer_pending", mod_pending, 1);
    chk("defer_mod_old", mod_active, 10);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("defer_at9", count, 9);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("defer_wrap_count", count, 0);
    chk("defer_wrap_mod", mod_active, 6);
    chk("defer_wrap_pending", mod_pending, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("defer_top", count, 5);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("defer_wrap2_count", count, 0);
    chk("defer_wrap2_pulse", wrap, 1);

    // Asynchronous reset with a modulus pending
    step(1, 1, 0, 0, 0, 1, 3);
    chk("pre_rst_pending", mod_pending, 1);
    rst_n = 0;
    #2;
    chk("async_rst_count", count, 0);
    chk("async_rst_mod", mod_active, 10);
    chk("async_rst_pending", mod_pending, 0);
    chk("async_rst_wrap", wrap, 0);
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    step(1, 1, 0, 0, 0, 0, 0);
    chk("post_rst_count", count, 1);
    chk("post_rst_mod", mod_active, 10);

    // Randomized run against the model
    for (int i = 0; i < 600; i++) begin
      bit e, d, c, l, mw;
      int lv, mv;
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      c  = ($urandom_range(0, 15) == 0);
      l  = ($urandom_range(0, 9) == 0);
      mw = ($urandom_range(0, 7) == 0);
      lv = $urandom_range(0, 20);
      mv = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 12);
      step(e, d, c, l, lv, mw, mv);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_mod_counter.md
PROG_MOD_COUNTER -- requirements
Module: prog_mod_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the counter and modulus width in bits.
REQ-002 The module SHALL have parameter DEFAULT_MOD, default 10, giving the modulus loaded at reset (legal range 1..2^WIDTH-1).
REQ-003 The module SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port en  input  1  count enable.
REQ-006 The module SHALL have port dir  input  1  count direction: 1 = up, 0 = down.
REQ-007 The module SHALL have port clr  input  1  synchronous clear.
REQ-008 The module SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 The module SHALL have port load_val  input  WIDTH  value for load.
REQ-010 The module SHALL have port mod_wr  input  1  modulus write strobe.
REQ-011 The module SHALL have port mod_val  input  WIDTH  new modulus value.
REQ-012 The module SHALL have port count  output  WIDTH  current count, registered.
REQ-013 The module SHALL have port tc  output  1  terminal count, combinational: en high and count at its wrap point for the current dir.
REQ-014 The module SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.
REQ-015 The module SHALL have port mod_active  output  WIDTH  modulus currently in force (M).
REQ-016 The module SHALL have port mod_pending  output  1  high while a written modulus awaits application.
REQ-017 The module SHALL have port load_err  output  1  registered one-cycle pulse flagging a clamped load.

Function
REQ-018 Control priority per cycle SHALL be clr > load > en; the lower-priority actions are ignored in that cycle.
REQ-019 With en=1, dir=1 and count < M-1, count SHALL increment by 1; with count = M-1 it SHALL wrap to 0.
REQ-020 With en=1, dir=0 and count > 0, count SHALL decrement by 1; with count = 0 it SHALL wrap to M-1.
REQ-021 With en=0 and no clr/load, count SHALL hold.
REQ-022 tc SHALL equal en & ((dir & count==M-1) | (~dir & count==0)); wrap SHALL assert exactly one cycle after each edge on which a count step wrapped.
REQ-023 M=1 SHALL hold count at 0 with tc=en, and wrap pulsing every enabled cycle.
REQ-024 mod_wr with mod_val=0 SHALL be ignored and leave the pending state unchanged; mod_wr with mod_val≥1 SHALL store mod_val in a pending register and set mod_pending (a later write overwrites an earlier one).
REQ-025 A pending modulus SHALL become M only on an edge where a wrap, clr or load takes effect; mod_pending SHALL clear on that same edge.
REQ-026 On a down-wrap that applies a pending modulus P, count SHALL become P-1; on an up-wrap it SHALL become 0.
REQ-027 mod_wr coincident with an applying edge SHALL be captured as the new pending value and SHALL not be applied on that edge.
REQ-028 load SHALL set count to load_val if load_val < M_new (M_new = pending modulus if mod_pending, else M); otherwise count SHALL be set to M_new-1 and load_err SHALL pulse the next cycle.
REQ-029 clr SHALL set count to 0, apply any pending modulus, and SHALL not generate wrap.
REQ-030 Changing dir while enabled SHALL take effect on the next edge with no extra latency.
REQ-031 All arithmetic SHALL be WIDTH bits unsigned; count SHALL never exceed M-1.

Reset
REQ-032 On rst_n low, count=0, M=DEFAULT_MOD, pending cleared, mod_pending=0, wrap=0, load_err=0, immediately and asynchronously.
REQ-033 Reset deasserted mid-sequence SHALL resume counting from 0 with DEFAULT_MOD on the first enabled edge; an unapplied pending modulus is lost.

Verification
REQ-034 Reset, en=1, dir=1, 12 edges -> count 0..9,0,1; tc high at count=9; wrap high the cycle after the edge from 9 to 0.
REQ-035 dir=0 from count=0, M=10 -> count 9,8,...; wrap after the edge from 0 to 9; toggle dir at count=5 -> next edge yields 6.
REQ-036 count=4, mod_wr mod_val=6 -> mod_pending=1, count continues 5..9, wraps to 0, mod_active=6, next wrap after count=5.
REQ-037 load with load_val=15, M=10 -> count=9, load_err pulse; load and clr together -> count=0, no load_err.
REQ-038 mod_wr with mod_val=0 -> no change; mod_val=1 -> after next clr, count stays 0, wrap pulses every enabled cycle.
REQ-039 Assert rst_n low mid-count with a modulus pending -> count=0, mod_active=DEFAULT_MOD, mod_pending=0 without waiting for a clock edge.
